// File: rtl/dp_ram_pkg.sv
// Shared constants for the parametrised dual-port RAM.
package dp_ram_pkg;

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  localparam int PRIO_A = 0;
  localparam int PRIO_B = 1;

endpackage

// File: rtl/dp_ram_init_ctrl.sv
// INIT/RUN sequencer: sweeps a zero write over every word after reset.
module dp_ram_init_ctrl
  import dp_ram_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 32,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              init_busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);
  localparam logic RST_ST =
    (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;

  logic              state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      if (cnt_q == LAST) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RST_ST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_busy_o = (state_q == ST_INIT);
  assign clr_we_o    = (state_q == ST_INIT);
  assign clr_addr_o  = cnt_q;

endmodule

// File: rtl/dp_ram_param.sv
// Single-clock true dual-port RAM with registered reads,
// configurable same-address behaviour and a post-reset clear.
module dp_ram_param
  import dp_ram_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 32,
  parameter int RD_MODE    = 0,
  parameter int COLL_PRIO  = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_valid,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_valid,
  output logic              collision
);

  localparam logic [ADDR_W:0] DEPTH_W =
    (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  dp_ram_init_ctrl #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .INIT_CLEAR(INIT_CLEAR)
  ) u_init (
    .clk_i      (clk),
    .rst_i      (rst),
    .init_busy_o(init_busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  logic run;
  logic a_ok, b_ok, same;
  logic a_wr, b_wr, a_rd, b_rd;
  logic dual_wr, a_wr_eff, b_wr_eff;

  assign run  = ~init_busy;
  assign a_ok = ({1'b0, a_addr} < DEPTH_W);
  assign b_ok = ({1'b0, b_addr} < DEPTH_W);
  assign same = (a_addr == b_addr);

  assign a_wr = run & a_en & a_we & a_ok;
  assign b_wr = run & b_en & b_we & b_ok;
  assign a_rd = run & a_en & ~a_we;
  assign b_rd = run & b_en & ~b_we;

  // On a same-address dual write only the priority port lands.
  assign dual_wr  = a_wr & b_wr & same;
  assign a_wr_eff = a_wr &
    ~(dual_wr & (COLL_PRIO == PRIO_B));
  assign b_wr_eff = b_wr &
    ~(dual_wr & (COLL_PRIO == PRIO_A));

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (a_wr_eff) mem_q[a_addr] <= a_din;
      if (b_wr_eff) mem_q[b_addr] <= b_din;
    end
  end

  logic [DATA_W-1:0] a_rdata, b_rdata;

  always_comb begin
    a_rdata = '0;
    b_rdata = '0;
    if (a_ok) begin
      a_rdata = mem_q[a_addr];
      if (RD_MODE == WR_FIRST && b_wr && same)
        a_rdata = b_din;
    end
    if (b_ok) begin
      b_rdata = mem_q[b_addr];
      if (RD_MODE == WR_FIRST && a_wr && same)
        b_rdata = a_din;
    end
  end

  logic [DATA_W-1:0] a_dout_q, a_dout_d;
  logic [DATA_W-1:0] b_dout_q, b_dout_d;
  logic              a_valid_q, b_valid_q;
  logic              coll_q, coll_d;

  assign a_dout_d = a_rd ? a_rdata : a_dout_q;
  assign b_dout_d = b_rd ? b_rdata : b_dout_q;
  assign coll_d   = run & a_en & b_en & same &
                    a_ok & (a_we | b_we);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_dout_q  <= '0;
      b_dout_q  <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      a_dout_q  <= a_dout_d;
      b_dout_q  <= b_dout_d;
      a_valid_q <= a_rd;
      b_valid_q <= b_rd;
      coll_q    <= coll_d;
    end
  end

  assign a_dout    = a_dout_q;
  assign b_dout    = b_dout_q;
  assign a_valid   = a_valid_q;
  assign b_valid   = b_valid_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_dp_ram_param.sv
// Directed bench: default instance plus a 24-word write-first, B-priority one.
module tb_dp_ram_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_en = 0, a_we = 0, b_en = 0, b_we = 0;
  logic [4:0] a_addr = 0, b_addr = 0;
  logic [3:0] a_din = 0, b_din = 0;

  logic       busy0, av0, bv0, co0;
  logic [3:0] ad0, bd0;
  logic       busy1, av1, bv1, co1;
  logic [3:0] ad1, bd1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dp_ram_param u_dut0 (
    .clk(clk), .rst(rst), .init_busy(busy0),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr),
    .a_din(a_din), .a_dout(ad0), .a_valid(av0),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr),
    .b_din(b_din), .b_dout(bd0), .b_valid(bv0),
    .collision(co0)
  );

  dp_ram_param #(
    .DEPTH(24), .RD_MODE(1), .COLL_PRIO(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .init_busy(busy1),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr),
    .a_din(a_din), .a_dout(ad1), .a_valid(av1),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr),
    .b_din(b_din), .b_dout(bd1), .b_valid(bv1),
    .collision(co1)
  );

  typedef struct {
    int a_en, a_we, a_addr, a_din;
    int b_en, b_we, b_addr, b_din;
    int av, ad0, ad1;
    int bv, bd0, bd1;
    int co;
  } vec_t;

  vec_t v [18];

  task automatic chk(input string nm,
                     input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " a_dout0"}, int'(ad0), 0);
    chk({nm, " b_dout0"}, int'(bd0), 0);
    chk({nm, " valids0"}, int'({av0, bv0, co0}), 0);
    chk({nm, " a_dout1"}, int'(ad1), 0);
    chk({nm, " valids1"}, int'({av1, bv1, co1}), 0);
    chk({nm, " busy"}, int'({busy0, busy1}), 3);
  endtask

  // Release reset, count busy cycles, and issue reads during INIT.
  task automatic release_and_clear(input string nm);
    int n0, n1, vbad;
    n0 = 0; n1 = 0; vbad = 0;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      a_en = (i < 20); a_we = 0;
      b_en = (i < 20); b_we = 0;
      a_addr = 5'(i); b_addr = 5'(i);
      if (busy0) n0++;
      if (busy1) n1++;
      tick();
      if (i < 20 && (av0 | av1 | bv0 | bv1)) vbad++;
    end
    a_en = 0; b_en = 0;
    chk({nm, " busy0 cycles"}, n0, 32);
    chk({nm, " busy1 cycles"}, n1, 24);
    chk({nm, " valid in INIT"}, vbad, 0);
  endtask

  task automatic read_all_zero(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      a_en = 1; a_we = 0; a_addr = 5'(i);
      tick();
      checks++;
      if (!(av0 && av1 && ad0 == 0 && ad1 == 0)) begin
        bad++;
        errors++;
        $display("FAIL %s addr %0d: v=%b%b d=%0d/%0d expected 11 0/0",
                 nm, i, av0, av1, ad0, ad1);
      end
    end
    a_en = 0;
    tick();
    chk({nm, " valid drops"}, int'({av0, av1}), 0);
  endtask

  initial begin
    // a_en we addr din, b_en we addr din, av ad0 ad1, bv bd0 bd1, co
    v[0]  = '{1,1, 3, 4, 1,1, 7, 9, 0, 0,0, 0, 0,0, 0};
    v[1]  = '{1,0, 3, 0, 1,0, 7, 0, 1, 4,4, 1, 9,9, 0};
    v[2]  = '{1,1, 5,12, 1,1, 5, 7, 0, 4,4, 0, 9,9, 1};
    v[3]  = '{1,0, 5, 0, 0,0, 0, 0, 1,12,7, 0, 9,9, 0};
    v[4]  = '{1,1,10, 2, 0,0, 0, 0, 0,12,7, 0, 9,9, 0};
    v[5]  = '{1,1,10, 6, 1,0,10, 0, 0,12,7, 1, 2,6, 1};
    v[6]  = '{0,0, 0, 0, 1,0,10, 0, 0,12,7, 1, 6,6, 0};
    v[7]  = '{1,1, 0, 1, 1,1, 1, 2, 0,12,7, 0, 6,6, 0};
    v[8]  = '{1,1, 2, 3, 0,0, 0, 0, 0,12,7, 0, 6,6, 0};
    v[9]  = '{1,0, 0, 0, 0,0, 0, 0, 1, 1,1, 0, 6,6, 0};
    v[10] = '{1,0, 1, 0, 0,0, 0, 0, 1, 2,2, 0, 6,6, 0};
    v[11] = '{1,0, 2, 0, 0,0, 0, 0, 1, 3,3, 0, 6,6, 0};
    v[12] = '{0,0, 0, 0, 0,0, 0, 0, 0, 3,3, 0, 6,6, 0};
    v[13] = '{1,0, 2, 0, 1,0, 2, 0, 1, 3,3, 1, 3,3, 0};
    v[14] = '{1,1,30, 5, 0,0, 0, 0, 0, 3,3, 0, 3,3, 0};
    v[15] = '{1,0,30, 0, 1,0,30, 0, 1, 5,0, 1, 5,0, 0};
    v[16] = '{1,0, 6, 0, 1,1, 6, 8, 1, 0,8, 0, 5,0, 1};
    v[17] = '{1,0, 6, 0, 1,0, 6, 0, 1, 8,8, 1, 8,8, 0};

    #12;
    chk_reset_vals("reset");
    tick();
    release_and_clear("clear1");
    read_all_zero("zero1");

    for (int i = 0; i < 18; i++) begin
      a_en = 1'(v[i].a_en); a_we = 1'(v[i].a_we);
      a_addr = 5'(v[i].a_addr); a_din = 4'(v[i].a_din);
      b_en = 1'(v[i].b_en); b_we = 1'(v[i].b_we);
      b_addr = 5'(v[i].b_addr); b_din = 4'(v[i].b_din);
      tick();
      chk($sformatf("v%0d a_valid", i), int'(av0), v[i].av);
      chk($sformatf("v%0d a_valid1", i), int'(av1), v[i].av);
      chk($sformatf("v%0d a_dout0", i), int'(ad0), v[i].ad0);
      chk($sformatf("v%0d a_dout1", i), int'(ad1), v[i].ad1);
      chk($sformatf("v%0d b_valid", i), int'(bv0), v[i].bv);
      chk($sformatf("v%0d b_valid1", i), int'(bv1), v[i].bv);
      chk($sformatf("v%0d b_dout0", i), int'(bd0), v[i].bd0);
      chk($sformatf("v%0d b_dout1", i), int'(bd1), v[i].bd1);
      chk($sformatf("v%0d coll0", i), int'(co0), v[i].co);
      chk($sformatf("v%0d coll1", i), int'(co1), v[i].co);
    end
    a_en = 0; b_en = 0;
    tick();
    chk("coll drops", int'({co0, co1}), 0);

    // Reset in the middle of a read burst.
    a_en = 1; a_we = 0; a_addr = 5'd3;
    b_en = 1; b_we = 0; b_addr = 5'd7;
    tick();
    chk("burst a_dout0", int'(ad0), 4);
    #2 rst = 1'b1;
    #1;
    a_en = 0; b_en = 0;
    chk_reset_vals("rst mid-run");
    tick();
    release_and_clear("clear2");
    read_all_zero("zero2");

    // Refill a word, then reset at INIT cycle 10.
    a_en = 1; a_we = 1; a_addr = 5'd4; a_din = 4'd9;
    tick();
    a_en = 0;
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid-INIT busy", int'({busy0, busy1}), 3);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("rst mid-init");
    tick();
    release_and_clear("clear3");
    read_all_zero("zero3");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dp_ram_param.md
Name: dp_ram_param

Overview:
Parametrised single-clock true dual-port RAM: the successor to the 32x4 dual-port RAM.
- Two independent read/write ports, A and B, with registered (1-cycle) reads and a per-port read-valid strobe.
- Configurable behaviour when both ports touch the same address in one cycle, with a collision flag.
- Post-reset clear sequencer that zeroes the whole array before accepting traffic.
- Used as the shared scratch/buffer memory between two datapath agents in the same clock domain.

Parameters:
DATA_W, 4, data width in bits (>=1)
ADDR_W, 5, address width in bits (>=1)
DEPTH, 32, number of words (2 <= DEPTH <= 2**ADDR_W)
RD_MODE, 0, cross-port read/write same address: 0 = read-first (old data), 1 = write-first (new data)
COLL_PRIO, 0, dual write to same address: 0 = port A data stored, 1 = port B data stored
INIT_CLEAR, 1, 1 = run zero-clear sweep after reset; 0 = skip it (contents undefined)

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
init_busy  out  1  high while the clear sweep runs; requests are ignored while high
a_en  in  1  port A request this cycle
a_we  in  1  port A write (1) / read (0); qualified by a_en
a_addr  in  ADDR_W  port A address
a_din  in  DATA_W  port A write data
a_dout  out  DATA_W  port A registered read data
a_valid  out  1  one-cycle pulse: a_dout holds the result of the read issued the previous cycle
b_en, b_we, b_addr, b_din, b_dout, b_valid  same as port A, for port B
collision  out  1  one-cycle pulse: a same-address conflict occurred in the previous cycle

Behaviour:
- Reset (async assert): a_dout = b_dout = 0; a_valid = b_valid = collision = 0; FSM -> INIT if INIT_CLEAR = 1, else -> RUN. init_busy = 1 during reset when INIT_CLEAR = 1, otherwise 0.
- FSM states: INIT, RUN.
  - INIT: clear counter starts at 0 and writes 0 to mem[cnt] each cycle. At cnt = DEPTH-1 it moves to RUN.
  - init_busy is high for exactly DEPTH cycles after rst deasserts, and drops on the cycle RUN is entered.
  - In INIT all a_en/b_en are ignored: no write, no valid pulse.
- Reset asserted mid-INIT or mid-RUN: all outputs return to their reset values immediately; the sweep restarts from address 0 after release. Memory contents are not otherwise guaranteed.
- Read (en = 1, we = 0) in RUN:
  - dout updates on the next posedge; valid = 1 for that one cycle.
  - Back-to-back reads give one result per cycle.
  - dout holds its last value when there is no read; it is not cleared.
- Write (en = 1, we = 1) in RUN: mem[addr] <= din at the posedge. dout and valid are unaffected on that port.
- Address >= DEPTH (only possible when DEPTH < 2**ADDR_W): writes are dropped; reads return 0 with valid = 1.
- Both ports write the same address: the COLL_PRIO port's data is stored and collision pulses next cycle.
- One port writes and the other reads the same address: the reader gets old data (RD_MODE = 0) or the written data (RD_MODE = 1). collision pulses next cycle.
- Both ports read the same address: legal, both get the same data, no collision.
- Different addresses: fully independent, no interaction.
- In RUN the memory is accessed by the two ports only; the clear counter is idle.

Decomposition:
- Shared package dp_ram_pkg:
  - state encoding constants ST_INIT = 1'b0, ST_RUN = 1'b1
  - RD_MODE constants RD_FIRST = 0, WR_FIRST = 1
  - COLL_PRIO constants PRIO_A = 0, PRIO_B = 1
- One sub-module, dp_ram_init_ctrl: the INIT/RUN FSM plus the clear counter. Outputs init_busy, clr_we and clr_addr.
- The array, the port logic and the collision resolution stay in the top level.

Test Plan:
1. Reset clear (defaults): release rst -> init_busy high for exactly 32 cycles; reads issued during INIT give no a_valid. Afterwards, read A at every address 0..31 -> a_dout = 0 with a_valid one cycle after each request.
2. Basic ports: A writes 4 at addr 3, B writes 9 at addr 7; then A reads 3 and B reads 7 in the same cycle -> next cycle a_dout = 4, b_dout = 9, both valid = 1, collision = 0.
3. Dual write, COLL_PRIO = 0: A writes 12 and B writes 7, both at addr 5, same cycle -> collision = 1 for one cycle; a later read of addr 5 returns 12. Rerun with COLL_PRIO = 1 -> returns 7.
4. Read/write same address: mem[10] = 2; A writes 6 at addr 10 while B reads addr 10 -> b_dout = 2 with RD_MODE = 0, 6 with RD_MODE = 1; collision = 1.
5. Streaming and hold: A reads addrs 0, 1, 2 back to back (data 1, 2, 3) -> a_dout = 1, 2, 3 on consecutive cycles with a_valid high throughout. Then a_en = 0 -> a_valid = 0 and a_dout holds 3.
6. Reset mid-operation: assert rst during a read burst and at INIT cycle 10 -> outputs go to 0 at once; after release init_busy is high for a full 32 cycles and all locations read 0.
